// File: rtl/mux_scan_nto1.sv
// Registered N:1 W-bit channel selector with manual index mode and round-robin
// scan mode (DWELL cycles per channel); outputs carry channel tag, valid and wrap.

module mux_scan_lane #(
    parameter int W    = 1,
    parameter int SELW = 3,
    parameter int IDX  = 0
) (
    input  logic [W-1:0]    d,
    input  logic [SELW-1:0] idx,
    output logic [W-1:0]    q
);
    assign q = (idx == SELW'(IDX)) ? d : '0;
endmodule

module mux_scan_nto1 #(
    parameter int N     = 8,
    parameter int W     = 1,
    parameter int SELW  = 3,
    parameter int DWELL = 4
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [N*W-1:0]  din,
    input  logic            en,
    input  logic            mode,
    input  logic [SELW-1:0] sel,
    output logic [W-1:0]    dout,
    output logic [SELW-1:0] ch,
    output logic            valid,
    output logic            wrap
);
    localparam int CNTW = (DWELL > 1) ? $clog2(DWELL) : 1;
    localparam logic [CNTW-1:0] CNT_LAST = CNTW'(DWELL - 1);
    localparam logic [SELW-1:0] CH_LAST  = SELW'(N - 1);
    localparam logic [SELW:0]   N_EXT    = (SELW+1)'(N);

    typedef enum logic [1:0] {IDLE, MANUAL, SCAN} state_t;

    state_t              state_q, state_d;
    logic [CNTW-1:0]     cnt_q, cnt_d;
    logic [SELW-1:0]     ch_d;
    logic                valid_d, wrap_d, hold_dout;
    logic [W-1:0]        sel_data, dout_d;
    logic [N-1:0][W-1:0] lane_q;

    // One lane per channel; a lane passes its data only when its index matches,
    // so an out-of-range index naturally selects zero.
    genvar gi;
    generate
        for (gi = 0; gi < N; gi++) begin : g_lane
            mux_scan_lane #(.W(W), .SELW(SELW), .IDX(gi)) u_lane (
                .d   (din[gi*W +: W]),
                .idx (ch_d),
                .q   (lane_q[gi])
            );
        end
    endgenerate

    always_comb begin
        sel_data = '0;
        for (int i = 0; i < N; i++)
            sel_data = sel_data | lane_q[i];
    end

    always_comb begin
        state_d = IDLE;
        if (rst)
            state_d = IDLE;
        else if (!en)
            state_d = IDLE;
        else if (!mode)
            state_d = MANUAL;
        else
            state_d = SCAN;
    end

    // Data path is driven by the state being entered on this edge, so
    // dout/ch/valid always move together.
    always_comb begin
        ch_d      = ch;
        cnt_d     = '0;
        valid_d   = 1'b0;
        wrap_d    = 1'b0;
        hold_dout = 1'b1;
        case (state_d)
            MANUAL: begin
                ch_d      = sel;
                valid_d   = ({1'b0, sel} < N_EXT);
                hold_dout = 1'b0;
            end
            SCAN: begin
                valid_d   = 1'b1;
                hold_dout = 1'b0;
                if (state_q != SCAN) begin
                    ch_d  = '0;
                    cnt_d = '0;
                end else if (cnt_q == CNT_LAST) begin
                    cnt_d = '0;
                    if (ch == CH_LAST) begin
                        ch_d   = '0;
                        wrap_d = 1'b1;
                    end else begin
                        ch_d = ch + SELW'(1);
                    end
                end else begin
                    cnt_d = cnt_q + CNTW'(1);
                end
            end
            default: ;
        endcase
        dout_d = hold_dout ? dout : sel_data;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            ch      <= '0;
            dout    <= '0;
            valid   <= 1'b0;
            wrap    <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            ch      <= ch_d;
            dout    <= dout_d;
            valid   <= valid_d;
            wrap    <= wrap_d;
        end
    end
endmodule

// File: tb/tb_mux_scan_nto1.sv
// Three instances (8ch dwell 4, 8ch dwell 1, 6ch dwell 3) share control inputs
// and are checked every edge against a tick-count reference model.

module tb_mux_scan_nto1;
    logic        clk = 1'b0;
    logic        rst, en, mode;
    logic [2:0]  sel;
    logic [31:0] din_a;
    logic [23:0] din_c;
    logic [3:0]  dout_a, dout_b, dout_c;
    logic [2:0]  ch_a, ch_b, ch_c;
    logic        valid_a, valid_b, valid_c, wrap_a, wrap_b, wrap_c;

    int vectors = 0;
    int errors  = 0;

    always #5 clk = ~clk;

    mux_scan_nto1 #(.N(8), .W(4), .SELW(3), .DWELL(4)) dut_a (
        .clk(clk), .rst(rst), .din(din_a), .en(en), .mode(mode), .sel(sel),
        .dout(dout_a), .ch(ch_a), .valid(valid_a), .wrap(wrap_a));
    mux_scan_nto1 #(.N(8), .W(4), .SELW(3), .DWELL(1)) dut_b (
        .clk(clk), .rst(rst), .din(din_a), .en(en), .mode(mode), .sel(sel),
        .dout(dout_b), .ch(ch_b), .valid(valid_b), .wrap(wrap_b));
    mux_scan_nto1 #(.N(6), .W(4), .SELW(3), .DWELL(3)) dut_c (
        .clk(clk), .rst(rst), .din(din_c), .en(en), .mode(mode), .sel(sel),
        .dout(dout_c), .ch(ch_c), .valid(valid_c), .wrap(wrap_c));

    // Reference model: scan position is an integer tick count since entry.
    int         m_n[3] = '{8, 8, 6};
    int         m_d[3] = '{4, 1, 3};
    bit         m_scan[3];
    int         m_tick[3];
    logic [3:0] m_dout[3];
    logic [2:0] m_ch[3];
    logic       m_valid[3], m_wrap[3];

    function automatic logic [3:0] chan(int k, int c);
        return (k == 2) ? din_c[c*4 +: 4] : din_a[c*4 +: 4];
    endfunction

    task automatic model_edge();
        for (int k = 0; k < 3; k++) begin
            if (rst) begin
                m_scan[k] = 0; m_dout[k] = '0; m_ch[k] = '0;
                m_valid[k] = 0; m_wrap[k] = 0;
            end else if (!en) begin
                m_scan[k] = 0; m_valid[k] = 0; m_wrap[k] = 0;
            end else if (!mode) begin
                m_scan[k] = 0; m_ch[k] = sel; m_wrap[k] = 0;
                if (int'(sel) < m_n[k]) begin
                    m_dout[k] = chan(k, int'(sel)); m_valid[k] = 1;
                end else begin
                    m_dout[k] = '0; m_valid[k] = 0;
                end
            end else begin
                if (!m_scan[k]) begin
                    m_scan[k] = 1; m_tick[k] = 0;
                end else begin
                    m_tick[k]++;
                end
                m_ch[k]    = 3'((m_tick[k] / m_d[k]) % m_n[k]);
                m_wrap[k]  = (m_tick[k] > 0) && (m_tick[k] % (m_n[k] * m_d[k]) == 0);
                m_dout[k]  = chan(k, int'(m_ch[k]));
                m_valid[k] = 1;
            end
        end
    endtask

    task automatic edge_step();
        @(posedge clk);
        model_edge();
        #1;
    endtask

    function automatic logic [26:0] obs();
        return {dout_a, ch_a, valid_a, wrap_a, dout_b, ch_b, valid_b, wrap_b,
                dout_c, ch_c, valid_c, wrap_c};
    endfunction

    function automatic logic [26:0] expv();
        return {m_dout[0], m_ch[0], m_valid[0], m_wrap[0],
                m_dout[1], m_ch[1], m_valid[1], m_wrap[1],
                m_dout[2], m_ch[2], m_valid[2], m_wrap[2]};
    endfunction

    task automatic ramp_data();
        for (int i = 0; i < 8; i++) din_a[i*4 +: 4] = 4'(i + 1);
        for (int i = 0; i < 6; i++) din_c[i*4 +: 4] = 4'(i + 1);
    endtask

    task automatic test_reset();
        rst = 1; en = 1; mode = 1; sel = '0; ramp_data();
        for (int i = 0; i < 2; i++) begin
            edge_step();
            vectors++;
            if (obs() !== expv() || obs() !== 27'd0) begin
                errors++;
                $display("FAIL reset cyc%0d: got %h want %h", i, obs(), expv());
            end
        end
        rst = 0;
        edge_step();
        vectors++;
        if (obs() !== expv() || ch_a !== 3'd0 || dout_a !== 4'h1) begin
            errors++;
            $display("FAIL reset_release_entry: got %h want %h", obs(), expv());
        end
    endtask

    task automatic test_manual();
        mode = 0; ramp_data();
        sel = 3'd5;
        edge_step();
        vectors++;
        if (obs() !== expv() || dout_a !== 4'h6 || !valid_a) begin
            errors++;
            $display("FAIL manual_sel5: got %h want %h", obs(), expv());
        end
        sel = 3'd2;
        edge_step();
        vectors++;
        if (obs() !== expv() || dout_a !== 4'h3) begin
            errors++;
            $display("FAIL manual_sel2: got %h want %h", obs(), expv());
        end
        for (int i = 0; i < 16; i++) begin
            sel = 3'($urandom_range(0, 7));
            din_a = $urandom; din_c = 24'($urandom);
            edge_step();
            vectors++;
            if (obs() !== expv()) begin
                errors++;
                $display("FAIL manual_rand%0d: got %h want %h", i, obs(), expv());
            end
        end
    endtask

    task automatic test_scan();
        ramp_data(); mode = 1;
        for (int i = 1; i <= 40; i++) begin
            edge_step();
            vectors++;
            if (obs() !== expv() || wrap_a !== (i == 33)) begin
                errors++;
                $display("FAIL scan_cyc%0d: got %h want %h", i, obs(), expv());
            end
        end
        for (int i = 0; i < 24; i++) begin
            din_a = $urandom; din_c = 24'($urandom);
            edge_step();
            vectors++;
            if (obs() !== expv()) begin
                errors++;
                $display("FAIL scan_live%0d: got %h want %h", i, obs(), expv());
            end
        end
    endtask

    task automatic test_out_of_range();
        logic [2:0] sels [3] = '{3'd7, 3'd6, 3'd4};
        mode = 0; ramp_data();
        for (int i = 0; i < 3; i++) begin
            sel = sels[i];
            edge_step();
            vectors++;
            if (obs() !== expv() || valid_c !== (i == 2) || ch_c !== sels[i]) begin
                errors++;
                $display("FAIL oor_sel%0d: got %h want %h", sels[i], obs(), expv());
            end
        end
    endtask

    task automatic test_enable_drop();
        mode = 1; ramp_data();
        for (int i = 0; i < 13; i++) edge_step();
        vectors++;
        if (obs() !== expv() || ch_a !== 3'd3) begin
            errors++;
            $display("FAIL en_pre: got %h want %h", obs(), expv());
        end
        en = 0; din_a = $urandom;
        edge_step();
        vectors++;
        if (obs() !== expv() || ch_a !== 3'd3 || dout_a !== 4'h4 || valid_a) begin
            errors++;
            $display("FAIL en_drop: got %h want %h", obs(), expv());
        end
        en = 1;
        edge_step();
        vectors++;
        if (obs() !== expv() || ch_a !== 3'd0 || !valid_a || wrap_a) begin
            errors++;
            $display("FAIL en_restore: got %h want %h", obs(), expv());
        end
    endtask

    task automatic test_reset_collide();
        mode = 0; edge_step();
        mode = 1; ramp_data();
        for (int i = 0; i < 21; i++) edge_step();
        vectors++;
        if (obs() !== expv() || ch_a !== 3'd5) begin
            errors++;
            $display("FAIL collide_pre: got %h want %h", obs(), expv());
        end
        rst = 1; mode = 0; sel = 3'd2;
        edge_step();
        vectors++;
        if (obs() !== expv() || obs() !== 27'd0) begin
            errors++;
            $display("FAIL collide_rst: got %h want %h", obs(), expv());
        end
        rst = 0;
    endtask

    task automatic test_random();
        for (int i = 0; i < 300; i++) begin
            rst  = ($urandom_range(0, 49) == 0);
            en   = ($urandom_range(0, 9) != 0);
            mode = ($urandom_range(0, 5) != 0);
            sel  = 3'($urandom_range(0, 7));
            din_a = $urandom; din_c = 24'($urandom);
            edge_step();
            vectors++;
            if (obs() !== expv()) begin
                errors++;
                $display("FAIL random%0d: got %h want %h", i, obs(), expv());
            end
        end
    endtask

    initial begin
        for (int k = 0; k < 3; k++) begin
            m_scan[k] = 0; m_tick[k] = 0; m_dout[k] = '0; m_ch[k] = '0;
            m_valid[k] = 0; m_wrap[k] = 0;
        end
        rst = 1; en = 0; mode = 0; sel = '0; din_a = '0; din_c = '0;
        @(negedge clk);
        test_reset();
        test_manual();
        test_scan();
        test_out_of_range();
        test_enable_drop();
        test_reset_collide();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end
endmodule
